// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared constants and types for the machine interrupt controller.
// Register offsets are byte offsets from the controller base address.
package irq_ctrl_pkg;

  localparam logic [4:0] OFF_PEND  = 5'h00;
  localparam logic [4:0] OFF_EN    = 5'h04;
  localparam logic [4:0] OFF_TYPE  = 5'h08;
  localparam logic [4:0] OFF_MSIP  = 5'h0C;
  localparam logic [4:0] OFF_CLAIM = 5'h10;
  localparam logic [4:0] OFF_CTRL  = 5'h14;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACTIVE
  } irq_state_e;

endpackage

// File: rtl/irq_src_cond.sv
// irq_src_cond: per-line conditioning (sampling/sync, edge detect, pending bit).
// IRQ_CTRL_SYNC_EN selects a 2-flop synchronizer instead of a single sampling flop.
module irq_src_cond (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic irq_i,
  input  logic edge_i,
  input  logic clr_i,
  output logic pend_o
);

  logic line;
  logic prev_q;
  logic pend_q;

`ifdef IRQ_CTRL_SYNC_EN
  logic [1:0] sync_q;

  // two-stage synchronizer for asynchronous lines
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) sync_q <= '0;
    else            sync_q <= {sync_q[0], irq_i};
  end

  assign line = sync_q[1];
`else
  logic samp_q;

  // single sampling flop, line assumed synchronous
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) samp_q <= 1'b0;
    else            samp_q <= irq_i;
  end

  assign line = samp_q;
`endif

  // pending bit: level follows line, edge sets on rise (set beats clear)
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev_q <= line;
      if (!edge_i)
        pend_q <= line;
      else if (line && !prev_q)
        pend_q <= 1'b1;
      else if (clr_i)
        pend_q <= 1'b0;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/irq_ctrl_wishbone.sv
// irq_ctrl_wishbone: machine interrupt controller, Wishbone slave, req/ack to core.
// IRQ_CTRL_SYNC_EN enables 2-flop synchronizers on ext_irq_i (see irq_src_cond).
module irq_ctrl_wishbone
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_EXT   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0D00
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  input  logic               mtip_i,
  input  logic [NUM_EXT-1:0] ext_irq_i,
  output logic               irq_req_o,
  output logic [4:0]         irq_cause_o,
  input  logic               irq_ack_i
);

  logic               ack_q, hold_q;
  logic [31:0]        dat_q, rdata;
  logic               acc, hit, wr, rd, claim_rd;
  logic               sel_pend, sel_en, sel_type;
  logic               sel_msip, sel_claim, sel_ctrl;
  logic [4:0]         off;
  logic [NUM_EXT-1:0] en_q, type_q, in_svc_q;
  logic [NUM_EXT-1:0] pend, avail, clr, svc_set, svc_clr;
  logic               msip_q, mie_q, ext_any, src_on;
  logic [4:0]         claim_id;
  logic [4:0]         cause_q, cause_d, last_q, last_d;
  irq_state_e         state_q, state_d;
  logic               unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];

  assign acc = wb_cyc_i & wb_stb_i & ~ack_q & ~hold_q;
  assign hit = (wb_adr_i[31:5] == BASE_ADDR[31:5]);
  assign wr  = acc & hit & wb_we_i;
  assign rd  = acc & hit & ~wb_we_i;
  assign off = {wb_adr_i[4:2], 2'b00};

  assign sel_pend  = (off == OFF_PEND);
  assign sel_en    = (off == OFF_EN);
  assign sel_type  = (off == OFF_TYPE);
  assign sel_msip  = (off == OFF_MSIP);
  assign sel_claim = (off == OFF_CLAIM);
  assign sel_ctrl  = (off == OFF_CTRL);
  assign claim_rd  = rd & sel_claim;

  assign avail   = pend & en_q & ~in_svc_q;
  assign ext_any = |avail;

  // lowest available line wins the claim
  always_comb begin
    claim_id = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--)
      if (avail[i]) claim_id = 5'(i + 1);
  end

  // per-line claim/complete strobes and edge-pending clears
  always_comb begin
    svc_set = '0;
    svc_clr = '0;
    clr     = '0;
    for (int i = 0; i < NUM_EXT; i++) begin
      svc_set[i] = claim_rd && (claim_id == 5'(i + 1));
      svc_clr[i] = wr && sel_claim && (wb_dat_i == 32'(i + 1));
      clr[i]     = svc_set[i] | (wr & sel_pend & wb_dat_i[i]);
    end
  end

  for (genvar g = 0; g < NUM_EXT; g++) begin : g_src
    irq_src_cond u_src (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_ni (wb_rst_ni),
      .irq_i     (ext_irq_i[g]),
      .edge_i    (type_q[g]),
      .clr_i     (clr[g]),
      .pend_o    (pend[g])
    );
  end

  // register read mux
  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (1'b1)
        sel_pend:  rdata[NUM_EXT-1:0] = pend;
        sel_en:    rdata[NUM_EXT-1:0] = en_q;
        sel_type:  rdata[NUM_EXT-1:0] = type_q;
        sel_msip:  rdata = {31'd0, msip_q};
        sel_claim: rdata = {27'd0, claim_id};
        sel_ctrl:  rdata = {25'd0, last_q, 1'b0, mie_q};
        default:   rdata = '0;
      endcase
    end
  end

  // bus handshake: one-cycle ack, rearmed only after strobe drops
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q  <= 1'b0;
      hold_q <= 1'b0;
      dat_q  <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc && !wb_we_i) ? rdata : '0;
      if (!(wb_cyc_i && wb_stb_i)) hold_q <= 1'b0;
      else if (ack_q)              hold_q <= 1'b1;
    end
  end

  // writable registers and in-service tracking
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      en_q     <= '0;
      type_q   <= '0;
      msip_q   <= 1'b0;
      mie_q    <= 1'b0;
      in_svc_q <= '0;
    end else begin
      in_svc_q <= (in_svc_q & ~svc_clr) | svc_set;
      if (wr && sel_en)   en_q   <= wb_dat_i[NUM_EXT-1:0];
      if (wr && sel_type) type_q <= wb_dat_i[NUM_EXT-1:0];
      if (wr && sel_msip) msip_q <= wb_dat_i[0];
      if (wr && sel_ctrl) mie_q  <= wb_dat_i[0];
    end
  end

  // request FSM state, latched cause and last acked cause
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      last_q  <= last_d;
    end
  end

  // request FSM next state: fixed priority ext > sw > timer
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    last_d  = last_q;
    src_on  = mtip_i;
    if (cause_q == CAUSE_MEI)      src_on = ext_any;
    else if (cause_q == CAUSE_MSI) src_on = msip_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mie_q && (ext_any || msip_q || mtip_i)) begin
          state_d = ST_REQ;
          cause_d = ext_any ? CAUSE_MEI :
                    msip_q  ? CAUSE_MSI : CAUSE_MTI;
        end
      end
      ST_REQ: begin
        if (irq_ack_i) begin
          state_d = ST_ACTIVE;
          last_d  = cause_q;
        end else if (!src_on || !mie_q) begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (!src_on) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign irq_req_o   = (state_q == ST_REQ);
  assign irq_cause_o = cause_q;

endmodule

// File: doc/irq_ctrl_wishbone.md
# irq_ctrl_wishbone

Machine-level interrupt controller that sits directly downstream of the CLINT timer: it consumes the CLINT `mtip` level, a software-interrupt bit it owns, and `NUM_EXT` external interrupt lines. It latches and masks these sources and arbitrates them by fixed priority. It then presents a single interrupt request with a cause code to the core over a req/ack handshake. It is a Wishbone slave on the same bus as the CLINT, at base `0x2000_0D00`.

## Interface
- `NUM_EXT`, 8: number of external interrupt lines (1..31).
- `BASE_ADDR`, 32'h2000_0D00: word-aligned register base.
- `wb_clk_i` in 1: single clock for all logic.
- `wb_rst_ni` in 1: reset, asynchronous, active-low.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1: Wishbone classic cycle, strobe, write enable.
- `wb_adr_i` in 32: byte address.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: registered read data.
- `wb_ack_o` out 1: registered acknowledge.
- `mtip_i` in 1: timer pending level from the CLINT, synchronous to `wb_clk_i`.
- `ext_irq_i` in `NUM_EXT`: external interrupt lines, possibly asynchronous.
- `irq_req_o` out 1: interrupt request to the core.
- `irq_cause_o` out 5: mcause code, valid while `irq_req_o` is high.
- `irq_ack_i` in 1: the core has taken the trap for `irq_cause_o`.

## Operation
- Registers, at offsets from `BASE_ADDR`:
  - 0x00 PEND: external pending bits. RO for level sources, W1C for edge sources.
  - 0x04 EN: external enable bits.
  - 0x08 TYPE: 1 selects edge (rising), 0 selects level.
  - 0x0C MSIP: bit0 is the software interrupt.
  - 0x10 CLAIM: read to claim; write an id to complete.
  - 0x14 CTRL: bit0 MIE (global enable); bits 6:2 hold the last acked cause (RO).
- Unmapped offsets read 0 and ignore writes. Registers are reset to 0.
- Pending logic:
  - A level source's pending bit equals its synchronized line.
  - An edge source's pending bit sets on a rising edge.
  - An edge pending bit clears on W1C or on claim.
  - If set and clear happen in the same cycle, set wins.
- `ext_any` = |(PEND & EN & ~in_service).
- Priority is fixed: external (cause 11) > software (cause 3, MSIP) > timer (cause 7, `mtip_i`).
- CLAIM read:
  - Returns id = lowest enabled pending, not-in-service index + 1, or 0 if none.
  - Sets `in_service[id-1]` and clears the edge pending bit.
- CLAIM write of id: clears `in_service[id-1]`. Out-of-range ids are ignored.
- FSM states IDLE, REQ, ACTIVE:
  - IDLE → REQ when MIE and (ext_any | MSIP | mtip_i). The highest-priority cause is latched into `irq_cause_o`.
  - REQ: `irq_req_o`=1 and the cause is held stable with no preemption.
    - On `irq_ack_i` → ACTIVE, and the cause is recorded in CTRL.
    - If the latched source is no longer asserted, or MIE=0, go to IDLE without ack (withdrawal).
  - ACTIVE: `irq_req_o`=0. Return to IDLE once the latched source deasserts:
    - Timer: `mtip_i`=0.
    - Software: MSIP=0.
    - External: ext_any=0.
  - `irq_ack_i` outside REQ is ignored.
- Reset mid-operation: the FSM goes to IDLE asynchronously, `irq_req_o` drops, and pending/in_service are cleared.

## Timing
- Reset values: `wb_dat_o`=0, `wb_ack_o`=0, `irq_req_o`=0, `irq_cause_o`=0.
- Wishbone:
  - `wb_ack_o` rises one cycle after `cyc&stb`. It is high for one cycle and is not reasserted until `stb` has been low for a cycle.
  - Read data is valid with ack.
  - A write takes effect at the ack edge.
- Synchronization latency, with `IRQ_CTRL_SYNC_EN`: an `ext_irq_i` change sampled at edge k is visible in PEND after edge k+2.
- Request latency: `irq_req_o` rises the cycle after the source condition is visible in IDLE. `mtip_i` rising at edge k gives `irq_req_o` high after edge k+1.
- Ack handling: `irq_req_o` falls the cycle after `irq_ack_i` is sampled high.

## Configuration
- `IRQ_CTRL_SYNC_EN` defined: each `ext_irq_i` passes through a 2-flop synchronizer before edge/level logic, giving 2-cycle latency.
- Undefined: one sampling flop only, giving 1-cycle latency. Inputs must then be synchronous.
- `mtip_i` is never synchronized.

## Structure
- Package `irq_ctrl_pkg`:
  - Register offset localparams.
  - Cause constants `CAUSE_MSI`=3, `CAUSE_MTI`=7, `CAUSE_MEI`=11.
  - FSM enum `irq_state_e`.
- Sub-module `irq_src_cond`, one instance per external line: synchronizer (macro-gated), edge detect, and pending bit with W1C/claim clear.

## Test plan
- Timer: MIE=1, `mtip_i` 0→1 → `irq_req_o`=1 with cause 7 next cycle. Ack → req drops. `mtip_i`→0 → FSM returns to IDLE.
- Priority: MSIP=1, `mtip_i`=1 and `ext_irq_i[2]`=1 (EN=0x04, level) in the same cycle → cause 11. CLAIM read returns 3.
- Edge: TYPE=0x01, EN=0x01, pulse `ext_irq_i[0]` for 1 cycle (sync on) → PEND=0x01 after 2 edges. W1C 0x01 coincident with a new edge → PEND stays 0x01.
- Claim/complete: claim returns 1 and sets in_service. A second claim returns 0. Writing 1 to CLAIM → a re-pulse raises req again.
- Withdrawal: MSIP=1 → REQ; write MSIP=0 before ack → `irq_req_o`=0 with no ack needed, and the FSM is in IDLE.
- Reset: assert `wb_rst_ni`=0 during REQ → `irq_req_o`, `wb_ack_o` and PEND are 0 immediately, without waiting for a clock edge.
